// File: rtl/fp_align_shifter.sv
// Mantissa alignment for the FP adder: picks the larger-exponent operand and right-shifts the smaller
// mantissa with G/R/S sticky; iterative STEP bits/cycle, or single-cycle barrel when FP_ALIGN_BARREL_EN is defined.
module fp_align_shifter #(
  parameter int STEP = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  exp_a,
  input  logic [7:0]  exp_b,
  input  logic [23:0] man_a,
  input  logic [23:0] man_b,
  input  logic [7:0]  diff,
  input  logic        a_ge_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  exp_out,
  output logic [23:0] man_big,
  output logic [26:0] man_small,
  output logic        swapped
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  localparam logic [4:0] MAX_SH = 5'd27;

  state_t      state_q, state_d;
  logic [7:0]  exp_q, exp_d;
  logic [23:0] big_q, big_d;
  logic [26:0] al_q, al_d;
  logic        swp_q, swp_d;
  logic [4:0]  rem_q, rem_d;

  logic [7:0]  shamt;
  logic [4:0]  r_in;
  logic [4:0]  step_amt;

  // Right shift where every bit falling off position 0 is folded into the sticky bit.
  function automatic logic [26:0] sticky_shr(input logic [26:0] x, input logic [4:0] s);
    logic lost;
    lost = 1'b0;
    for (int i = 0; i < 27; i++) begin
      if (5'(i) < s) lost = lost | x[i];
    end
    return (x >> s) | {26'd0, lost};
  endfunction

  assign shamt = a_ge_b ? diff : (~diff + 8'd1);
  assign r_in  = (shamt > 8'd27) ? MAX_SH : shamt[4:0];

`ifdef FP_ALIGN_BARREL_EN
  assign step_amt = rem_q;
`else
  localparam logic [4:0] STEP_C = 5'(STEP);
  assign step_amt = (rem_q > STEP_C) ? STEP_C : rem_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      exp_q   <= 8'd0;
      big_q   <= 24'd0;
      al_q    <= 27'd0;
      swp_q   <= 1'b0;
      rem_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      big_q   <= big_d;
      al_q    <= al_d;
      swp_q   <= swp_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = (r_in == 5'd0) ? S_DONE : S_SHIFT;
      S_SHIFT: if (rem_q == step_amt) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    exp_d = exp_q;
    big_d = big_q;
    swp_d = swp_q;
    al_d  = al_q;
    rem_d = rem_q;
    if (state_q == S_IDLE && in_valid) begin
      exp_d = a_ge_b ? exp_a : exp_b;
      big_d = a_ge_b ? man_a : man_b;
      swp_d = ~a_ge_b;
      al_d  = {(a_ge_b ? man_b : man_a), 3'b000};
      rem_d = r_in;
    end else if (state_q == S_SHIFT) begin
      al_d  = sticky_shr(al_q, step_amt);
      rem_d = rem_q - step_amt;
    end
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    exp_out   = exp_q;
    man_big   = big_q;
    man_small = al_q;
    swapped   = swp_q;
  end

endmodule

// File: tb/tb_fp_align_shifter.sv
// Directed bench for fp_align_shifter with an arithmetic reference model and per-cycle output compare.
module tb_fp_align_shifter;

  localparam int STEP = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [7:0]  exp_a, exp_b, diff;
  logic [23:0] man_a, man_b;
  logic        a_ge_b;
  logic        out_valid, out_ready;
  logic [7:0]  exp_out;
  logic [23:0] man_big;
  logic [26:0] man_small;
  logic        swapped;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0]  e;
    logic [23:0] big;
    logic [26:0] sm;
    logic        sw;
    int          lat;
  } exp_t;

  exp_t cur;
  bit   exp_active = 1'b0;

  fp_align_shifter #(.STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .exp_a(exp_a), .exp_b(exp_b), .man_a(man_a), .man_b(man_b),
    .diff(diff), .a_ge_b(a_ge_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .exp_out(exp_out), .man_big(man_big), .man_small(man_small), .swapped(swapped)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Reference: the exact shift of {small,000} by min(shamt,27), sticky = any nonzero bit lost.
  function automatic exp_t model(input logic [7:0] ea, input logic [7:0] eb, input logic [23:0] ma,
                                 input logic [23:0] mb, input logic [7:0] d, input logic ge);
    exp_t m;
    int sh, r;
    longint unsigned v, res;
    sh = ge ? int'(d) : (256 - int'(d)) % 256;
    r  = (sh > 27) ? 27 : sh;
    v  = longint'(ge ? mb : ma) * 8;
    res = v >> r;
    if ((v & ((64'd1 << r) - 64'd1)) != 0) res = res | 64'd1;
    m.e   = ge ? ea : eb;
    m.big = ge ? ma : mb;
    m.sw  = ~ge;
    m.sm  = res[26:0];
`ifdef FP_ALIGN_BARREL_EN
    m.lat = (r == 0) ? 1 : 2;
`else
    m.lat = (r + STEP - 1) / STEP + 1;
`endif
    return m;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && exp_active) begin
      check("exp_out", exp_out, cur.e);
      check("man_big", man_big, cur.big);
      check("man_small", man_small, cur.sm);
      check("swapped", swapped, cur.sw);
    end
  end

  task automatic do_op(input logic [7:0] ea, input logic [7:0] eb, input logic [23:0] ma,
                       input logic [23:0] mb, input logic [7:0] d, input logic ge,
                       input int hold, input logic [26:0] lit_sm, input bit use_lit);
    int n;
    @(posedge clk); #1;
    exp_a = ea; exp_b = eb; man_a = ma; man_b = mb; diff = d; a_ge_b = ge;
    in_valid = 1'b1;
    check("in_ready_idle", in_ready, 1);
    cur = model(ea, eb, ma, mb, d, ge);
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_active = 1'b1;
    n = 1;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, cur.lat);
    if (use_lit) check("literal_man_small", man_small, lit_sm);
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0];
      exp_a = 8'($urandom); exp_b = 8'($urandom); diff = 8'($urandom);
      man_a = 24'($urandom); man_b = 24'($urandom); a_ge_b = 1'($urandom);
      @(posedge clk); #1;
      check("in_ready_stall", in_ready, 0);
      check("out_valid_stall", out_valid, 1);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    exp_active = 1'b0;
    check("post_out_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    exp_a = 8'd0; exp_b = 8'd0; diff = 8'd0; man_a = 24'd0; man_b = 24'd0; a_ge_b = 1'b0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_exp_out", exp_out, 0);
    check("rst_man_big", man_big, 0);
    check("rst_man_small", man_small, 0);
    check("rst_swapped", swapped, 0);
    #5 rst_n = 1'b1;
    #1 check("rst_in_ready", in_ready, 1);

    do_op(8'h85, 8'h80, 24'hABCDEF, 24'h800000, 8'h05, 1'b1, 0, 27'h0200000, 1);
    do_op(8'h80, 8'h90, 24'hFFFFFF, 24'h912345, 8'hF0, 1'b0, 0, 27'h00007FF, 1);
    do_op(8'h7F, 8'h7F, 24'hC00000, 24'h123456, 8'h00, 1'b1, 0, 27'h091A2B0, 1);
    do_op(8'hD0, 8'h08, 24'hABCDEF, 24'h800001, 8'hC8, 1'b1, 10, 27'h0000001, 1);
    do_op(8'h7E, 8'h7F, 24'h800003, 24'h400000, 8'hFF, 1'b0, 0, 27'h200000C, 1);
    do_op(8'h88, 8'h80, 24'h9A9A9A, 24'h800001, 8'h08, 1'b1, 0, 27'h0040001, 1);
    do_op(8'h89, 8'h80, 24'h9A9A9A, 24'h800001, 8'h09, 1'b1, 0, 27'h0020001, 1);

    // Reset landing in the second SHIFT cycle of a 27-bit shift.
    @(posedge clk); #1;
    exp_a = 8'hD0; exp_b = 8'h08; diff = 8'hC8; a_ge_b = 1'b1;
    man_a = 24'hFEDCBA; man_b = 24'h800001; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_exp_out", exp_out, 0);
    check("mid_rst_man_big", man_big, 0);
    check("mid_rst_man_small", man_small, 0);
    check("mid_rst_swapped", swapped, 0);
    #3 rst_n = 1'b1;
    #1 check("mid_rst_in_ready", in_ready, 1);
    do_op(8'h90, 8'h80, 24'h111111, 24'hFFFFFF, 8'h10, 1'b1, 0, 27'h00007FF, 1);

    for (int k = 0; k < 40; k++) begin
      logic [7:0]  ea, eb;
      logic [23:0] ma, mb;
      ea = 8'($urandom_range(30, 220));
      eb = 8'(int'(ea) + int'($urandom_range(0, 70)) - 35);
      ma = 24'($urandom) | 24'h800000;
      mb = 24'($urandom) | 24'h800000;
      do_op(ea, eb, ma, mb, ea - eb, (ea >= eb), k % 3, 27'd0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fp_align_shifter.md
# fp_align_shifter

Mantissa alignment stage of the single-precision FP adder, directly downstream of the exponent comparator. It accepts both operands' exponents and 24-bit mantissas (hidden bit included), plus the comparator's 8-bit difference and its carry-out. It selects the larger-exponent operand and right-shifts the smaller mantissa by the exponent difference, keeping guard, round and sticky bits. Shifting is iterative over several cycles, and a valid/ready handshake on both sides feeds the significand adder.

## Interface
- STEP, 8: maximum right-shift distance per SHIFT cycle; legal range 1..27.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input operands valid.
- in_ready  out  1  block can accept; high only in IDLE.
- exp_a, exp_b  in  8 each  biased exponents.
- man_a, man_b  in  24 each  mantissas with hidden bit.
- diff  in  8  comparator result, exp_a − exp_b mod 256.
- a_ge_b  in  1  comparator carry-out; 1 when exp_a ≥ exp_b.
- out_valid  out  1  aligned result valid.
- out_ready  in  1  downstream accepts.
- exp_out  out  8  larger exponent.
- man_big  out  24  mantissa of the larger-exponent operand.
- man_small  out  27  aligned smaller mantissa, bits [26:3] mantissa and [2:0] G/R/S.
- swapped  out  1  1 when operand b was the larger.

## Operation
- Shift amount: shamt = diff if a_ge_b = 1, else (~diff + 1) mod 256. The effective count is r = min(shamt, 27).
- Swap: if a_ge_b = 1, big = a and small = b, with swapped = 0. Otherwise big = b and small = a, with swapped = 1. Equal exponents give no swap.
- Alignment register: loads {small_man, 3'b000}. Each right shift ORs every bit shifted out of position 0 into bit 0, which is the sticky bit.
- FSM, three states:
  - IDLE: in_ready = 1. On in_valid && in_ready, capture exp_out, man_big, swapped and the alignment register, and set remaining = r. Go to DONE if r = 0, else to SHIFT.
  - SHIFT: s = min(remaining, STEP). Shift right by s with sticky accumulation and set remaining −= s. Go to DONE when remaining − s = 0.
  - DONE: out_valid = 1 and outputs are held stable. On out_ready go to IDLE.
- in_valid is ignored outside IDLE. No new operand is accepted in the cycle the result is consumed.
- A shift of 27 leaves man_small = {26'b0, |small_man}.
- Reset: async assertion forces IDLE from any state, including mid-SHIFT, and discards the in-flight operation. Reset values:
  - out_valid = 0, swapped = 0.
  - exp_out, man_big and man_small all zero.
  - in_ready = 1 once rst_n is deasserted.

## Timing
- The accept edge is E0. With k = ceil(r/STEP) (k = 0 when r = 0), out_valid goes high k+1 cycles after E0.
- With STEP = 8: worst case k = 4, latency 5 cycles. With STEP = 1: worst case latency 28 cycles.
- out_valid holds until the out_ready cycle. in_ready rises the cycle after the transfer.
- Throughput is one operation per k+2 cycles when out_ready is held high.
- All outputs are registered. There are no combinational paths from inputs to outputs except in_ready, which is state-decoded.

## Configuration
- FP_ALIGN_BARREL_EN defined: SHIFT performs the full r-bit shift with sticky in one cycle using a barrel shifter. k = 1 for r > 0 and 0 for r = 0, and STEP is ignored.
- Not defined: iterative STEP-per-cycle shifting as described above.
- Output values are bit-identical in both modes; only latency differs.

## Test plan
- exp_a=0x85, exp_b=0x80, diff=0x05, a_ge_b=1, man_b=0x800000, out_ready=1 → man_small=0x0200000, man_big=man_a, exp_out=0x85, swapped=0. out_valid 2 cycles after accept (STEP=8).
- exp_a=0x80, exp_b=0x90, diff=0xF0, a_ge_b=0, man_a=0xFFFFFF → shamt 16, swapped=1, exp_out=0x90, man_small=0x00007FF (sticky 1). Latency 3 cycles.
- diff=0x00, a_ge_b=1 → no shift, man_small={man_b,000}, latency 1 cycle. Same input with diff=200, a_ge_b=1, man_b=0x800001 → r clamps to 27, man_small=0x0000001, latency 5.
- out_ready held low 10 cycles after out_valid → outputs stable and in_ready=0 with in_valid pulsed throughout. out_ready=1 → one transfer, then IDLE.
- rst_n low during the second SHIFT cycle → out_valid=0 and all outputs 0 immediately. After release, a new operation completes with correct values.
- Build with FP_ALIGN_BARREL_EN and repeat the first three cases → identical outputs, latency 2, 2 and 1/2 cycles respectively.
